// File: rtl/rf_alu_datapath.sv
// rf_alu_datapath: sixteen 16-bit registers feeding a one-cycle ALU with a registered result.
// Define RF_ALU_FLAGS_EN to build the {C,L,F,Z,N} flag register; without it flags read 0 and CMP/CMPI do nothing.
module rf_alu_datapath (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  alu_op,
    input  logic [7:0]  muxes,
    input  logic [15:0] regs_en,
    input  logic [15:0] imm,
    output logic [15:0] result,
    output logic [4:0]  flags,
    input  logic [3:0]  dbg_sel,
    output logic [15:0] dbg_data
);
    typedef enum logic [3:0] {OP_NOP, OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB, OP_CMP, OP_MOV, OP_LSH, OP_LUI} op_e;
    op_e         w_op;
    logic        w_imm_src;
    logic [15:0] r_rf [16];
    logic [15:0] r_result;
    logic [15:0] w_a, w_b, w_sum, w_diff, w_lsh, w_alu;
    logic [4:0]  w_mag;
    logic        w_wr;
    // Unknown opcode bits match no case item, so x/z falls through to NOP.
    always_comb begin
        w_op = OP_NOP;
        w_imm_src = 1'b0;
        case (alu_op[7:4])
            4'h0: case (alu_op[3:0])
                4'h1: w_op = OP_AND;
                4'h2: w_op = OP_OR;
                4'h3: w_op = OP_XOR;
                4'h5: w_op = OP_ADD;
                4'h9: w_op = OP_SUB;
                4'hB: w_op = OP_CMP;
                4'hD: w_op = OP_MOV;
                default: w_op = OP_NOP;
            endcase
            4'h1: begin w_op = OP_AND; w_imm_src = 1'b1; end
            4'h2: begin w_op = OP_OR;  w_imm_src = 1'b1; end
            4'h3: begin w_op = OP_XOR; w_imm_src = 1'b1; end
            4'h5: begin w_op = OP_ADD; w_imm_src = 1'b1; end
            4'h9: begin w_op = OP_SUB; w_imm_src = 1'b1; end
            4'hB: begin w_op = OP_CMP; w_imm_src = 1'b1; end
            4'hD: begin w_op = OP_MOV; w_imm_src = 1'b1; end
            4'h8: w_op = (alu_op[3:0] == 4'h4) ? OP_LSH : OP_NOP;
            4'hF: w_op = OP_LUI;
            default: w_op = OP_NOP;
        endcase
    end
    assign w_a    = r_rf[muxes[7:4]];
    assign w_b    = w_imm_src ? imm : r_rf[muxes[3:0]];
    assign w_sum  = w_a + w_b;
    assign w_diff = w_a - w_b;
    // Shift amount is a signed 5-bit value; only -16 reaches a magnitude of 16.
    assign w_mag  = 5'd0 - w_b[4:0];
    assign w_lsh  = !w_b[4] ? (w_a << w_b[3:0]) : w_mag[4] ? 16'h0000 : (w_a >> w_mag[3:0]);
    assign w_alu  = (w_op == OP_AND) ? (w_a & w_b) :
                    (w_op == OP_OR)  ? (w_a | w_b) :
                    (w_op == OP_XOR) ? (w_a ^ w_b) :
                    (w_op == OP_ADD) ? w_sum :
                    (w_op == OP_SUB) ? w_diff :
                    (w_op == OP_MOV) ? w_b :
                    (w_op == OP_LSH) ? w_lsh :
                    (w_op == OP_LUI) ? {imm[7:0], 8'h00} : 16'h0000;
    assign w_wr   = (w_op != OP_NOP) && (w_op != OP_CMP);
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) r_rf[i] <= 16'h0000;
            r_result <= 16'h0000;
        end else if (w_wr) begin
            for (int i = 0; i < 16; i++) if (regs_en[i]) r_rf[i] <= w_alu;
            r_result <= w_alu;
        end
    end
    assign result   = r_result;
    assign dbg_data = r_rf[dbg_sel];
`ifdef RF_ALU_FLAGS_EN
    logic [4:0] r_flags;
    logic       w_add_c, w_add_v, w_sub_c, w_sub_v, w_slt;
    assign w_add_c = w_sum < w_a;
    assign w_add_v = (w_a[15] == w_b[15]) && (w_sum[15] != w_a[15]);
    assign w_sub_c = w_a < w_b;
    assign w_sub_v = (w_a[15] != w_b[15]) && (w_diff[15] != w_a[15]);
    assign w_slt   = $signed(w_a) < $signed(w_b);
    always_ff @(posedge clk) begin
        if (reset)
            r_flags <= 5'b00000;
        else if (w_op == OP_ADD)
            r_flags <= {w_add_c, r_flags[3], w_add_v, r_flags[1:0]};
        else if (w_op == OP_SUB)
            r_flags <= {w_sub_c, r_flags[3], w_sub_v, r_flags[1:0]};
        else if (w_op == OP_CMP)
            r_flags <= {r_flags[4], w_sub_c, r_flags[2], w_a == w_b, w_slt};
    end
    assign flags = r_flags;
`else
    assign flags = 5'b00000;
`endif
endmodule

// File: tb/tb_rf_alu_datapath.sv
// tb_rf_alu_datapath: directed scenarios plus randomized ops checked against an arithmetic reference model.
// Honors RF_ALU_FLAGS_EN the same way the design does.
module tb_rf_alu_datapath;
    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  alu_op, muxes;
    logic [15:0] regs_en, imm;
    logic [15:0] result, dbg_data;
    logic [4:0]  flags;
    logic [3:0]  dbg_sel;
    int n_checks = 0;
    int n_errors = 0;
`ifdef RF_ALU_FLAGS_EN
    localparam bit FL = 1'b1;
`else
    localparam bit FL = 1'b0;
`endif
    typedef enum {K_NOP, K_AND, K_OR, K_XOR, K_ADD, K_SUB, K_CMP, K_MOV, K_LSH, K_LUI} k_e;
    logic [15:0] m_rf [16];
    logic [15:0] m_res;
    logic [4:0]  m_flags;

    rf_alu_datapath dut (
        .clk(clk), .reset(reset), .alu_op(alu_op), .muxes(muxes), .regs_en(regs_en),
        .imm(imm), .result(result), .flags(flags), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void decode(input logic [7:0] op, output k_e k, output bit use_imm);
        k_e ops [16] = '{K_NOP, K_AND, K_OR, K_XOR, K_NOP, K_ADD, K_NOP, K_NOP,
                         K_NOP, K_SUB, K_NOP, K_CMP, K_NOP, K_MOV, K_NOP, K_NOP};
        k = K_NOP;
        use_imm = 1'b0;
        if ($isunknown(op)) return;
        if (op[7:4] == 4'h0) k = ops[op[3:0]];
        else if (op[7:4] == 4'h8) k = (op[3:0] == 4'h4) ? K_LSH : K_NOP;
        else if (op[7:4] == 4'hF) begin k = K_LUI; use_imm = 1'b1; end
        else if (ops[op[7:4]] != K_NOP) begin k = ops[op[7:4]]; use_imm = 1'b1; end
        if (k == K_CMP && !FL) k = K_NOP;
    endfunction

    function automatic int sgn(input int v);
        return (v >= 32768) ? v - 65536 : v;
    endfunction

    task automatic model(input logic [7:0] op, input logic [7:0] mx, input logic [15:0] en,
                         input logic [15:0] im, input logic rst);
        k_e k;
        bit ii;
        int a, b, r, sh, s;
        if (rst) begin
            for (int i = 0; i < 16; i++) m_rf[i] = 16'h0;
            m_res = 16'h0;
            m_flags = 5'h0;
            return;
        end
        decode(op, k, ii);
        a = int'(m_rf[mx[7:4]]);
        b = ii ? int'(im) : int'(m_rf[mx[3:0]]);
        r = 0;
        case (k)
            K_NOP: return;
            K_AND: r = a & b;
            K_OR:  r = a | b;
            K_XOR: r = a ^ b;
            K_MOV: r = b;
            K_LUI: r = (int'(im) % 256) * 256;
            K_ADD: begin
                r = (a + b) % 65536;
                s = sgn(a) + sgn(b);
                if (FL) begin m_flags[4] = (a + b) > 65535; m_flags[2] = (s > 32767) || (s < -32768); end
            end
            K_SUB: begin
                r = (a - b + 65536) % 65536;
                s = sgn(a) - sgn(b);
                if (FL) begin m_flags[4] = a < b; m_flags[2] = (s > 32767) || (s < -32768); end
            end
            K_CMP: begin
                m_flags[3] = a < b;
                m_flags[1] = a == b;
                m_flags[0] = sgn(a) < sgn(b);
                return;
            end
            K_LSH: begin
                sh = b % 32;
                if (sh >= 16) sh -= 32;
                r = (sh >= 0) ? (a << sh) % 65536 : (sh <= -16) ? 0 : a >> (-sh);
            end
            default: return;
        endcase
        m_res = r[15:0];
        for (int i = 0; i < 16; i++) if (en[i]) m_rf[i] = r[15:0];
    endtask

    task automatic check_all();
        check("result", result, m_res);
        check("flags", {11'h0, flags}, {11'h0, m_flags});
        for (int i = 0; i < 16; i++) begin
            dbg_sel = 4'(i);
            #1;
            check($sformatf("R%0d", i), dbg_data, m_rf[i]);
        end
    endtask

    task automatic step(input logic [7:0] op, input logic [7:0] mx, input logic [15:0] en,
                        input logic [15:0] im, input logic rst);
        alu_op = op; muxes = mx; regs_en = en; imm = im; reset = rst;
        model(op, mx, en, im, rst);
        @(posedge clk);
        #1;
        alu_op = 8'h00;
        reset = 1'b0;
        check_all();
    endtask

    task automatic read_reg(input int idx, output logic [15:0] v);
        dbg_sel = 4'(idx);
        #1;
        v = dbg_data;
    endtask

    initial begin
        logic [7:0]  pool [16] = '{8'h01, 8'h02, 8'h03, 8'h05, 8'h09, 8'h0B, 8'h0D, 8'h10,
                                   8'h20, 8'h30, 8'h50, 8'h90, 8'hB0, 8'hD0, 8'h84, 8'hF0};
        logic [15:0] v;
        logic [7:0]  op;
        logic [15:0] en;
        alu_op = 8'h00; muxes = 8'h00; regs_en = 16'h0; imm = 16'h0; reset = 1'b1; dbg_sel = 4'h0;
        for (int i = 0; i < 16; i++) m_rf[i] = 16'hxxxx;
        step(8'h00, 8'h00, 16'h0, 16'h0, 1'b1);
        step(8'h00, 8'h00, 16'h0, 16'h0, 1'b1);
        check("rst_result", result, 16'h0);
        check("rst_flags", {11'h0, flags}, 16'h0);
        // Fibonacci chain
        step(8'h50, 8'h10, 16'h0002, 16'h0001, 1'b0);
        for (int k = 2; k < 16; k++)
            step(8'h05, {4'(k - 2), 4'(k - 1)}, 16'(1 << k), 16'h0, 1'b0);
        read_reg(15, v);
        check("fib_R15", v, 16'h0262);
        check("fib_result", result, 16'h0262);
        // ADD carry and overflow
        step(8'hD0, 8'h00, 16'h0002, 16'hFFFF, 1'b0);
        step(8'hD0, 8'h00, 16'h0004, 16'h0001, 1'b0);
        step(8'h05, 8'h12, 16'h0008, 16'h0, 1'b0);
        check("add_carry_res", result, 16'h0000);
        check("add_carry_flags", {11'h0, flags}, FL ? 16'h0010 : 16'h0);
        step(8'hD0, 8'h00, 16'h0002, 16'h7FFF, 1'b0);
        step(8'h05, 8'h12, 16'h0008, 16'h0, 1'b0);
        check("add_ovf_res", result, 16'h8000);
        check("add_ovf_flags", {11'h0, flags}, FL ? 16'h0004 : 16'h0);
        // CMPI
        step(8'hD0, 8'h00, 16'h0002, 16'h0005, 1'b0);
        step(8'hB0, 8'h10, 16'hFFFF, 16'h0005, 1'b0);
        check("cmpi_eq_LZN", {13'h0, flags[3], flags[1], flags[0]}, FL ? 16'h0002 : 16'h0);
        check("cmpi_eq_res", result, 16'h0005);
        step(8'hB0, 8'h10, 16'hFFFF, 16'h0007, 1'b0);
        check("cmpi_lt_LZN", {13'h0, flags[3], flags[1], flags[0]}, FL ? 16'h0005 : 16'h0);
        read_reg(1, v);
        check("cmpi_R1", v, 16'h0005);
        // reset beats a simultaneous write, then a multi-register write
        step(8'h50, 8'h30, 16'h0008, 16'h0003, 1'b1);
        read_reg(3, v);
        check("rst_wins_R3", v, 16'h0);
        step(8'hD0, 8'h00, 16'h00F0, 16'h1234, 1'b0);
        for (int i = 4; i < 8; i++) begin
            read_reg(i, v);
            check($sformatf("movi_R%0d", i), v, 16'h1234);
        end
        // unknown opcode holds everything
        step(8'hxx, 8'h12, 16'hFFFF, 16'hBEEF, 1'b0);
        step(8'h84, 8'h45, 16'h0100, 16'h0, 1'b0);
        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            op = pool[$urandom_range(0, 15)];
            if (op[7:4] != 4'h0 && op[7:4] != 4'h8) op[3:0] = 4'($urandom);
            if ($urandom_range(0, 7) == 0) op = 8'($urandom);
            case ($urandom_range(0, 3))
                0: en = 16'h0;
                1: en = 16'(1 << $urandom_range(0, 15));
                2: en = 16'($urandom);
                default: en = 16'(3 << $urandom_range(0, 14));
            endcase
            step(op, 8'($urandom), en, 16'($urandom), $urandom_range(0, 49) == 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
